// File: rtl/multicycle_ctrl.sv
// ==== multicycle_ctrl : RV32I multi-cycle control FSM (ILLEGAL_TRAP_EN adds HALT + illegal) ====
// ==== Rev 1.0                                                                               ====
`default_nettype none

module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       alu_op,
  output logic             f7_force0,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             timeout,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic              gap, gap_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ready_ok;
  logic              wait_expired;
  logic              retire;

  assign ready_ok      = mem_req && mem_ready;
  assign wait_expired  = mem_req && !mem_ready && (wait_cnt == WAIT_LAST);
  assign timeout       = wait_expired;
  assign ir_write      = (state == S_FETCH) && ready_ok;
  assign pc_write      = (state == S_FETCH) && ready_ok;
  assign pc_write_cond = (state == S_BRANCH) && zero;

  // gap marks a FETCH cycle with mem_req held low after a request ended
  // (store completion or abort), so consecutive requests never merge.
  always_comb begin
    state_nxt = state;
    gap_nxt   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (ready_ok) begin
          state_nxt = S_DECODE;
        end else if (wait_expired) begin
          state_nxt = S_FETCH;
          gap_nxt   = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_nxt = S_EXEC_R;
          OP_I:               state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:          state_nxt = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:            state_nxt = S_HALT;
`else
          default:            state_nxt = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_WB_ALU: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (ready_ok) begin
          state_nxt = S_WB_MEM;
        end else if (wait_expired) begin
          state_nxt = S_FETCH;
          gap_nxt   = 1'b1;
        end
      end
      S_WB_MEM: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEM_WR: begin
        if (ready_ok || wait_expired) begin
          state_nxt = S_FETCH;
          gap_nxt   = 1'b1;
          retire    = ready_ok;
        end
      end
      S_BRANCH: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gap        <= 1'b0;
      wait_cnt   <= '0;
      retired    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_op     <= 2'b00;
      f7_force0  <= 1'b0;
      alu_src_a  <= 1'b0;
      alu_src_b  <= 2'b00;
`ifdef ILLEGAL_TRAP_EN
      illegal    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      gap        <= gap_nxt;
      wait_cnt   <= (mem_req && !mem_ready && !wait_expired) ? wait_cnt + WAIT_W'(1) : '0;
      if (retire) retired <= retired + CNT_W'(1);
      mem_req    <= ((state_nxt == S_FETCH) && !gap_nxt) ||
                    (state_nxt == S_MEM_RD) || (state_nxt == S_MEM_WR);
      mem_we     <= (state_nxt == S_MEM_WR);
      reg_write  <= (state_nxt == S_WB_ALU) || (state_nxt == S_WB_MEM);
      mem_to_reg <= (state_nxt == S_WB_MEM);
`ifdef ILLEGAL_TRAP_EN
      illegal    <= (state_nxt == S_HALT);
`endif
      case (state_nxt)
        S_FETCH:    begin alu_src_a <= 1'b0; alu_src_b <= 2'b01; alu_op <= 2'b00; f7_force0 <= 1'b0; end
        S_EXEC_R:   begin alu_src_a <= 1'b1; alu_src_b <= 2'b00; alu_op <= 2'b10; f7_force0 <= 1'b0; end
        S_EXEC_I:   begin alu_src_a <= 1'b1; alu_src_b <= 2'b10; alu_op <= 2'b10; f7_force0 <= 1'b1; end
        S_WB_ALU:   ; // keep the EXEC selection while writing back
        S_MEM_ADDR: begin alu_src_a <= 1'b1; alu_src_b <= 2'b10; alu_op <= 2'b00; f7_force0 <= 1'b0; end
        S_BRANCH:   begin alu_src_a <= 1'b1; alu_src_b <= 2'b00; alu_op <= 2'b01; f7_force0 <= 1'b0; end
        default:    begin alu_src_a <= 1'b0; alu_src_b <= 2'b00; alu_op <= 2'b00; f7_force0 <= 1'b0; end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ==== tb_multicycle_ctrl : scoreboard bench for multicycle_ctrl (honours ILLEGAL_TRAP_EN) ====
// ==== Rev 1.0                                                                              ====
`default_nettype none

module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_op;
    logic       f7_force0;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       mem_to_reg;
    logic       timeout;
  } outs_t;

  typedef struct {
    string            name;
    int               cyc;
    outs_t            outs;
    logic [CNT_W-1:0] ret;
    logic             ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, mem_we, ir_write, pc_write, pc_write_cond;
  logic [1:0]       alu_op;
  logic             f7_force0, alu_src_a;
  logic [1:0]       alu_src_b;
  logic             reg_write, mem_to_reg, timeout;
  logic             illegal_obs;
  logic [CNT_W-1:0] retired;

`ifdef ILLEGAL_TRAP_EN
  logic illegal;
  assign illegal_obs = illegal;
`else
  assign illegal_obs = 1'b0;
`endif

  multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .alu_op(alu_op), .f7_force0(f7_force0),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .timeout(timeout),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .retired(retired)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output patterns, one helper per FSM phase.
  function automatic outs_t e_fetch(input logic req, input logic done, input logic to);
    outs_t e = '0;
    e.mem_req = req; e.alu_src_b = 2'b01; e.ir_write = done; e.pc_write = done; e.timeout = to;
    return e;
  endfunction

  function automatic outs_t e_exec_r(input logic wb);
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_op = 2'b10; e.reg_write = wb;
    return e;
  endfunction

  function automatic outs_t e_exec_i(input logic wb);
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; e.f7_force0 = 1'b1; e.reg_write = wb;
    return e;
  endfunction

  function automatic outs_t e_maddr();
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    return e;
  endfunction

  function automatic outs_t e_mem(input logic we);
    outs_t e = '0;
    e.mem_req = 1'b1; e.mem_we = we;
    return e;
  endfunction

  function automatic outs_t e_wbmem();
    outs_t e = '0;
    e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_branch(input logic taken);
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = taken;
    return e;
  endfunction

  task automatic step(input string nm, input logic rdy, input logic z, input logic [6:0] op,
                      input outs_t e, input logic [CNT_W-1:0] r, input logic ill);
    exp_t x;
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    x.name = nm; x.cyc = cyc; x.outs = e; x.ret = r; x.ill = ill;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops every expectation due in the current cycle and compares.
  always @(negedge clk) begin
    outs_t act;
    exp_t  x;
    act = {mem_req, mem_we, ir_write, pc_write, pc_write_cond, alu_op, f7_force0,
           alu_src_a, alu_src_b, reg_write, mem_to_reg, timeout};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      n_checks++;
      if (x.cyc != cyc)
        $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", x.name, x.cyc, cyc);
      else if (act !== x.outs)
        $display("FAIL %s @%0d: outputs got %h want %h", x.name, cyc, act, x.outs);
      else
        n_pass++;
      n_checks++;
      if (retired !== x.ret)
        $display("FAIL %s_retired @%0d: got %0d want %0d", x.name, cyc, retired, x.ret);
      else
        n_pass++;
`ifdef ILLEGAL_TRAP_EN
      n_checks++;
      if (illegal_obs !== x.ill)
        $display("FAIL %s_illegal @%0d: got %b want %b", x.name, cyc, illegal_obs, x.ill);
      else
        n_pass++;
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1'b0, 1'b0, 7'd0, '0, 0, 1'b0);
    rst_n = 1'b1;
    step("idle", 1'b1, 1'b0, OP_R, '0, 0, 1'b0);

    // R-type, single-cycle fetch
    step("r_fetch",  1'b1, 1'b0, OP_R, e_fetch(1, 1, 0), 0, 1'b0);
    step("r_decode", 1'b1, 1'b0, OP_R, '0,               0, 1'b0);
    step("r_exec",   1'b1, 1'b0, OP_R, e_exec_r(0),      0, 1'b0);
    step("r_wb",     1'b1, 1'b0, OP_R, e_exec_r(1),      0, 1'b0);

    // I-type
    step("i_fetch",  1'b1, 1'b0, OP_I, e_fetch(1, 1, 0), 1, 1'b0);
    step("i_decode", 1'b1, 1'b0, OP_I, '0,               1, 1'b0);
    step("i_exec",   1'b1, 1'b0, OP_I, e_exec_i(0),      1, 1'b0);
    step("i_wb",     1'b1, 1'b0, OP_I, e_exec_i(1),      1, 1'b0);

    // Load, ready arrives on the 4th request cycle
    step("ld_fetch",  1'b1, 1'b0, OP_LOAD, e_fetch(1, 1, 0), 2, 1'b0);
    step("ld_decode", 1'b1, 1'b0, OP_LOAD, '0,               2, 1'b0);
    step("ld_addr",   1'b1, 1'b0, OP_LOAD, e_maddr(),        2, 1'b0);
    for (int i = 0; i < 3; i++)
      step("ld_wait", 1'b0, 1'b0, OP_LOAD, e_mem(0), 2, 1'b0);
    step("ld_done",   1'b1, 1'b0, OP_LOAD, e_mem(0),         2, 1'b0);
    step("ld_wb",     1'b1, 1'b0, OP_LOAD, e_wbmem(),        2, 1'b0);

    // Store; the following FETCH starts with a request-free gap that ignores mem_ready
    step("st_fetch",  1'b1, 1'b0, OP_STORE,  e_fetch(1, 1, 0), 3, 1'b0);
    step("st_decode", 1'b1, 1'b0, OP_STORE,  '0,               3, 1'b0);
    step("st_addr",   1'b1, 1'b0, OP_STORE,  e_maddr(),        3, 1'b0);
    step("st_write",  1'b1, 1'b0, OP_STORE,  e_mem(1),         3, 1'b0);
    step("st_gap",    1'b1, 1'b0, OP_BRANCH, e_fetch(0, 0, 0), 4, 1'b0);

    // Branch taken, then not taken
    step("bt_fetch",  1'b1, 1'b1, OP_BRANCH, e_fetch(1, 1, 0), 4, 1'b0);
    step("bt_decode", 1'b1, 1'b1, OP_BRANCH, '0,               4, 1'b0);
    step("bt_branch", 1'b1, 1'b1, OP_BRANCH, e_branch(1),      4, 1'b0);
    step("bn_fetch",  1'b1, 1'b0, OP_BRANCH, e_fetch(1, 1, 0), 5, 1'b0);
    step("bn_decode", 1'b1, 1'b0, OP_BRANCH, '0,               5, 1'b0);
    step("bn_branch", 1'b1, 1'b0, OP_BRANCH, e_branch(0),      5, 1'b0);

    // Fetch timeout: pulse on the 16th request cycle, one idle cycle, then re-request
    for (int i = 0; i < 16; i++)
      step("to_wait", 1'b0, 1'b0, OP_BAD, e_fetch(1, 0, (i == 15)), 6, 1'b0);
    step("to_gap",    1'b0, 1'b0, OP_BAD, e_fetch(0, 0, 0), 6, 1'b0);
    step("to_refetch",1'b1, 1'b0, OP_BAD, e_fetch(1, 1, 0), 6, 1'b0);
    step("bad_decode",1'b1, 1'b0, OP_BAD, '0,               6, 1'b0);

`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      step("halt", 1'b1, 1'b0, OP_STORE, '0, 6, 1'b1);
    rst_n = 1'b0;
    step("halt_rst", 1'b1, 1'b0, OP_STORE, '0, 6, 1'b1);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b0, OP_STORE, '0, 0, 1'b0);
    step("rst_fetch",1'b1, 1'b0, OP_STORE, e_fetch(1, 1, 0), 0, 1'b0);
`else
    // Unknown opcode is a NOP; then reset in the middle of a store request
    step("nop_fetch", 1'b1, 1'b0, OP_STORE, e_fetch(1, 1, 0), 6, 1'b0);
    step("rs_decode", 1'b1, 1'b0, OP_STORE, '0,               6, 1'b0);
    step("rs_addr",   1'b1, 1'b0, OP_STORE, e_maddr(),        6, 1'b0);
    rst_n = 1'b0;
    step("rs_write",  1'b0, 1'b0, OP_STORE, e_mem(1),         6, 1'b0);
    rst_n = 1'b1;
    step("post_rst",  1'b1, 1'b0, OP_STORE, '0,               0, 1'b0);
    step("rst_fetch", 1'b1, 1'b0, OP_STORE, e_fetch(1, 1, 0), 0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
